// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bundle between the ID/EX register and the EX-stage mul/div unit.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            flush_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [2:0]      funct3_i;
  logic [4:0]      rd_i;
  logic            stall_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  // Pipeline side: presents the instruction, observes stall and the result.
  modport master (
    output start_i, flush_i, rs1_i, rs2_i, funct3_i, rd_i,
    input  stall_o, valid_o, result_o, rd_o
  );

  // Unit side.
  modport slave (
    input  start_i, flush_i, rs1_i, rs2_i, funct3_i, rd_i,
    output stall_o, valid_o, result_o, rd_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring division over magnitudes, with sign fix-up on the final iteration.
// Fixed latency: result valid 32 cycles after acceptance.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ex_muldiv_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN:0]   hi_q, hi_d;     // mul: running upper product / div: partial remainder
  logic [XLEN-1:0] lo_q, lo_d;     // mul: multiplier shifting out / div: dividend -> quotient
  logic [XLEN-1:0] m_q, m_d;       // mul: multiplicand / div: divisor (magnitudes)
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      rdo_q, rdo_d;

  logic            accept;
  logic            s1, s2, a_neg, b_neg, start_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic [XLEN:0]   mul_sum, div_rs, step_hi;
  logic [XLEN+1:0] div_diff;
  logic            div_ok;
  logic [XLEN-1:0] step_lo, final_res;
  logic [2*XLEN-1:0] prod_s;

  function automatic logic [XLEN-1:0] cneg(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic n, input logic [2*XLEN-1:0] v);
    return n ? (~v + (2*XLEN)'(1)) : v;
  endfunction

  assign accept      = (state_q == S_IDLE) && bus.start_i && !bus.flush_i;
  assign bus.stall_o = accept || (state_q == S_BUSY);
  assign bus.valid_o = (state_q == S_DONE);
  assign bus.result_o = res_q;
  assign bus.rd_o     = rdo_q;

  // Operand decode at acceptance: which operands are signed, magnitudes, result sign.
  always_comb begin
    s1 = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b010) ||
         (bus.funct3_i == 3'b100) || (bus.funct3_i == 3'b110);
    s2 = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b100) ||
         (bus.funct3_i == 3'b110);
    a_neg = s1 && bus.rs1_i[XLEN-1];
    b_neg = s2 && bus.rs2_i[XLEN-1];
    mag1  = cneg(a_neg, bus.rs1_i);
    mag2  = cneg(b_neg, bus.rs2_i);
    if (!bus.funct3_i[2]) begin
      start_neg = a_neg ^ b_neg;
    end else if (bus.funct3_i[1]) begin
      // Remainder follows the dividend, also for a zero divisor (gives rs1 back).
      start_neg = a_neg;
    end else begin
      // Zero divisor must yield all ones, so never negate the quotient then.
      start_neg = (a_neg ^ b_neg) && (bus.rs2_i != '0);
    end
  end

  // One radix-2 iteration plus sign correction of the would-be final value.
  always_comb begin
    mul_sum  = lo_q[0] ? (hi_q + {1'b0, m_q}) : hi_q;
    div_rs   = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    div_diff = {1'b0, div_rs} - {2'b00, m_q};
    div_ok   = !div_diff[XLEN+1];
    if (op_q[2]) begin
      step_hi = div_ok ? div_diff[XLEN:0] : div_rs;
      step_lo = {lo_q[XLEN-2:0], div_ok};
    end else begin
      step_hi = {1'b0, mul_sum[XLEN:1]};
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod_s = cneg2(neg_q, {step_hi[XLEN-1:0], step_lo});
    case (op_q)
      3'b000:          final_res = prod_s[XLEN-1:0];
      3'b100, 3'b101:  final_res = cneg(neg_q, step_lo);
      3'b110, 3'b111:  final_res = cneg(neg_q, step_hi[XLEN-1:0]);
      default:         final_res = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  // Control FSM and datapath next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    rd_d    = rd_q;
    res_d   = res_q;
    rdo_d   = rdo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          op_d    = bus.funct3_i;
          neg_d   = start_neg;
          hi_d    = '0;
          lo_d    = bus.funct3_i[2] ? mag1 : mag2;
          m_d     = bus.funct3_i[2] ? mag2 : mag1;
          rd_d    = bus.rd_i;
        end
      end
      S_BUSY: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            res_d   = final_res;
            rdo_d   = rd_q;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      rdo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      rdo_q   <= rdo_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for the iterative RV32M mul/div unit.
module tb_ex_muldiv_unit;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  ex_muldiv_unit_if bus ();

  ex_muldiv_unit dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction and follow it through the fixed 32-cycle latency.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input bit toggle);
    int bad;
    bad = 0;
    bus.funct3_i = f3;
    bus.rs1_i    = a;
    bus.rs2_i    = b;
    bus.rd_i     = rd;
    bus.flush_i  = 1'b0;
    bus.start_i  = 1'b1;
    #1;
    check({tag, " stall@E0"}, {31'd0, bus.stall_o}, 32'd1);
    tick();  // E0
    for (int i = 1; i <= 31; i++) begin
      if (toggle) bus.start_i = ~bus.start_i;
      tick();
      if (bus.stall_o !== 1'b1 || bus.valid_o !== 1'b0) bad++;
    end
    check({tag, " busy-window"}, bad, 32'd0);
    tick();  // E32
    bus.start_i = 1'b0;
    check({tag, " valid"}, {31'd0, bus.valid_o}, 32'd1);
    check({tag, " stall@done"}, {31'd0, bus.stall_o}, 32'd0);
    check({tag, " result"}, bus.result_o, exp);
    check({tag, " rd"}, {27'd0, bus.rd_o}, {27'd0, rd});
    tick();  // E33
    check({tag, " valid-drop"}, {31'd0, bus.valid_o}, 32'd0);
    check({tag, " hold"}, bus.result_o, exp);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n        = 1'b0;
    bus.start_i  = 1'b0;
    bus.flush_i  = 1'b0;
    bus.rs1_i    = '0;
    bus.rs2_i    = '0;
    bus.funct3_i = '0;
    bus.rd_i     = '0;
    tick();
    tick();
    check("reset valid", {31'd0, bus.valid_o}, 32'd0);
    check("reset result", bus.result_o, 32'd0);
    check("reset rd", {27'd0, bus.rd_o}, 32'd0);
    check("reset stall", {31'd0, bus.stall_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Multiply family
    run_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 1'b0);
    run_op("MULH min*min", 3'b001, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000, 1'b0);
    run_op("MULHU max*max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, 1'b0);
    run_op("MULHSU -1*2", 3'b010, 32'hFFFFFFFF, 32'd2, 5'd8, 32'hFFFFFFFF, 1'b0);

    // Divide family
    run_op("DIV -7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD, 1'b0);
    run_op("REM -7/2", 3'b110, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, 1'b0);
    run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 5'd11, 32'd14, 1'b0);
    run_op("REMU 100/7", 3'b111, 32'd100, 32'd7, 5'd12, 32'd2, 1'b0);

    // Divide by zero and signed overflow
    run_op("DIV 5/0", 3'b100, 32'd5, 32'd0, 5'd13, 32'hFFFFFFFF, 1'b0);
    run_op("REM 5/0", 3'b110, 32'd5, 32'd0, 5'd14, 32'd5, 1'b0);
    run_op("DIV -5/0", 3'b100, 32'hFFFFFFFB, 32'd0, 5'd15, 32'hFFFFFFFF, 1'b0);
    run_op("REM -5/0", 3'b110, 32'hFFFFFFFB, 32'd0, 5'd16, 32'hFFFFFFFB, 1'b0);
    run_op("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1'b0);
    run_op("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0, 1'b0);

    // Start together with flush in IDLE: not accepted
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.funct3_i = 3'b000;
    bus.rs1_i = 32'd2;
    bus.rs2_i = 32'd2;
    #1;
    check("start+flush stall", {31'd0, bus.stall_o}, 32'd0);
    tick();
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    check("start+flush idle", {31'd0, bus.stall_o}, 32'd0);

    // Flush at counter=15
    bus.funct3_i = 3'b101;
    bus.rs1_i = 32'd1000;
    bus.rs2_i = 32'd3;
    bus.rd_i = 5'd20;
    bus.start_i = 1'b1;
    tick();  // E0
    for (int i = 1; i <= 15; i++) tick();
    bus.flush_i = 1'b1;
    #1;
    check("flush busy stall", {31'd0, bus.stall_o}, 32'd1);
    tick();
    check("flush stall drop", {31'd0, bus.stall_o}, 32'd0);
    check("flush no valid", {31'd0, bus.valid_o}, 32'd0);
    check("flush keeps result", bus.result_o, 32'd0);
    bus.flush_i = 1'b0;
    run_op("MUL after flush", 3'b000, 32'd6, 32'd7, 5'd21, 32'd42, 1'b1);

    // Reset mid-BUSY at counter=10
    bus.funct3_i = 3'b000;
    bus.rs1_i = 32'd9;
    bus.rs2_i = 32'd9;
    bus.rd_i = 5'd22;
    bus.start_i = 1'b1;
    tick();  // E0
    for (int i = 1; i <= 10; i++) tick();
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    #1;
    check("midrst valid", {31'd0, bus.valid_o}, 32'd0);
    check("midrst result", bus.result_o, 32'd0);
    check("midrst stall", {31'd0, bus.stall_o}, 32'd0);
    check("midrst rd", {27'd0, bus.rd_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post-rst stall", {31'd0, bus.stall_o}, 32'd0);
    check("post-rst valid", {31'd0, bus.valid_o}, 32'd0);
    run_op("MUL 3*4", 3'b000, 32'd3, 32'd4, 5'd1, 32'd12, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
